// File: rtl/igniter_pkg.sv
// -----------------------------------------------------------------------------
// igniter_pkg
// Shared types and constants for the igniter continuity scanner:
//   - scan_state_t : scan FSM state encoding
//   - ch_stat_t    : 2-bit per-channel result code
//   - *_DEF        : default values for the scanner parameters
//   - widths of the resistance, accumulator and phase datapaths
// -----------------------------------------------------------------------------
package igniter_pkg;

  localparam int NCH_DEF     = 4;      // igniter channels
  localparam int PWM_CYC_DEF = 96;     // 2 us of test current at 48 MHz
  localparam int SETTLE_DEF  = 256;    // phase at which sampling opens
  localparam int WINDOW_DEF  = 4096;   // phase at which sampling times out
  localparam int NSAMP_DEF   = 16;     // samples averaged per channel
  localparam int GAP_DEF     = 65535;  // phase ending the inter-channel holdoff

  localparam int RW      = 11;  // resistance magnitude width
  localparam int ACC_W   = 15;  // sample accumulator width
  localparam int PHASE_W = 16;  // phase counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_PULSE,
    ST_SETTLE,
    ST_MEAS,
    ST_EVAL,
    ST_GAP,
    ST_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    STAT_UNTESTED = 2'b00,
    STAT_OK       = 2'b01,
    STAT_OPEN     = 2'b10,
    STAT_SHORT    = 2'b11
  } ch_stat_t;

endpackage

// File: rtl/igniter_avg.sv
// -----------------------------------------------------------------------------
// igniter_avg
// Accumulates NSAMP resistance samples from the shared ohm divider and
// presents their average.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the accumulator and sample count (channel start)
//   enable     : samples are taken only while high (measurement window)
//   r_valid    : sample strobe
//   r_in       : sample, bit 11 sign, bits 10:0 inverted magnitude
//   full       : NSAMP samples have been accumulated
//   avg        : accumulator divided by NSAMP
// -----------------------------------------------------------------------------
module igniter_avg
  import igniter_pkg::*;
#(
  parameter int NSAMP = NSAMP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic          r_valid,
  input  logic [11:0]   r_in,
  output logic          full,
  output logic [RW-1:0] avg
);

  localparam int SH    = $clog2(NSAMP);
  localparam int CNT_W = SH + 1;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [RW-1:0]    mag;
  logic [ACC_W-1:0] shifted;
  logic             take;

  // Negative readings clamp to zero; positive ones arrive bit-inverted.
  assign mag     = r_in[11] ? '0 : (r_in[10:0] ^ 11'h7FF);
  assign full    = (count == CNT_W'(NSAMP));
  // Samples beyond NSAMP are dropped so the average stays exact.
  assign take    = enable && r_valid && !full;
  assign shifted = acc >> SH;
  assign avg     = shifted[RW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (take) begin
      acc   <= acc + ACC_W'(mag);
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/igniter_scan_ctrl.sv
// -----------------------------------------------------------------------------
// igniter_scan_ctrl
// Sequential continuity scanner for NCH igniter channels. For each masked
// channel it drives a test-current pulse, waits for the divider to settle,
// averages NSAMP resistance samples and classifies the channel as OK, OPEN
// or SHORT, then holds off before moving to the next channel.
//   clk, reset          : clock, asynchronous active-low reset
//   start               : request a scan (honoured only in IDLE)
//   abort               : drop the scan, back to IDLE on the next edge
//   ch_mask             : channels to scan, latched when a channel is selected
//   r_open_thr          : average above this -> OPEN (used in EVAL)
//   r_short_thr         : average below this -> SHORT (used in EVAL)
//   r_valid, r_in       : resistance sample strobe and value
//   pwm                 : test-current drive, high while pulsing
//   ch_sel              : selected channel for the divider and pwm mux
//   busy                : scan in progress
//   done                : one-cycle pulse at scan completion
//   res_valid/ch/r      : per-channel result strobe, index and average
//   ch_status           : 2-bit code per channel (see ch_stat_t)
// -----------------------------------------------------------------------------
module igniter_scan_ctrl
  import igniter_pkg::*;
#(
  parameter  int NCH     = NCH_DEF,
  parameter  int PWM_CYC = PWM_CYC_DEF,
  parameter  int SETTLE  = SETTLE_DEF,
  parameter  int WINDOW  = WINDOW_DEF,
  parameter  int NSAMP   = NSAMP_DEF,
  parameter  int GAP     = GAP_DEF,
  localparam int CW      = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [RW-1:0]    r_open_thr,
  input  logic [RW-1:0]    r_short_thr,
  input  logic             r_valid,
  input  logic [11:0]      r_in,
  output logic             pwm,
  output logic [CW-1:0]    ch_sel,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [CW-1:0]    res_ch,
  output logic [RW-1:0]    res_r,
  output logic [2*NCH-1:0] ch_status
);

  scan_state_t        state, next_state;
  logic [PHASE_W-1:0] phase;
  logic [NCH-1:0]     mask_q;

  logic               first_found, next_found;
  logic [CW-1:0]      first_idx, next_idx;

  logic               avg_clear, avg_enable, avg_full;
  logic [RW-1:0]      avg;
  logic               phase_run;
  ch_stat_t           eval_status;
  logic [RW-1:0]      eval_r;

  // Lowest set bit of mask at index >= lo, as {found, index}.
  function automatic logic [CW:0] pick_channel(input logic [NCH-1:0] mask,
                                               input int lo);
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  // The first channel comes from the live mask, later ones from the copy
  // latched at SEL.
  assign {first_found, first_idx} = pick_channel(ch_mask, 0);
  assign {next_found, next_idx}   = pick_channel(mask_q, int'(ch_sel) + 1);

  // ---------------------------------------------------------------- FSM
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state defaults to the current state before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (start) next_state = first_found ? ST_SEL : ST_DONE;
        ST_SEL:    next_state = ST_PULSE;
        ST_PULSE:  if (phase >= PHASE_W'(PWM_CYC - 1)) next_state = ST_SETTLE;
        ST_SETTLE: if (phase >= PHASE_W'(SETTLE)) next_state = ST_MEAS;
        ST_MEAS:   if (avg_full || (phase >= PHASE_W'(WINDOW))) next_state = ST_EVAL;
        ST_EVAL:   next_state = ST_GAP;
        ST_GAP:    if (phase >= PHASE_W'(GAP)) next_state = next_found ? ST_SEL : ST_DONE;
        ST_DONE:   next_state = ST_IDLE;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pwm        = (state == ST_PULSE);
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    avg_clear  = (state == ST_SEL);
    avg_enable = (state == ST_MEAS);
    phase_run  = (state == ST_PULSE) || (state == ST_SETTLE) ||
                 (state == ST_MEAS)  || (state == ST_GAP);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (state == ST_SEL) begin
      phase <= '0;
    end else if (phase_run && (phase != '1)) begin
      phase <= phase + PHASE_W'(1);
    end
  end

  // Channel select is loaded on every entry to SEL; abort forces IDLE as
  // next state, so an aborted request never moves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_sel <= '0;
      mask_q <= '0;
    end else begin
      if (next_state == ST_SEL) ch_sel <= (state == ST_IDLE) ? first_idx : next_idx;
      if (state == ST_SEL)      mask_q <= ch_mask;
    end
  end

  // MEAS only exits early through a full sample count, so a short count in
  // EVAL means the window expired.
  always_comb begin
    eval_r      = avg_full ? avg : {RW{1'b1}};
    eval_status = STAT_OK;
    if (!avg_full || (avg > r_open_thr)) eval_status = STAT_OPEN;
    else if (avg < r_short_thr)          eval_status = STAT_SHORT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_r     <= '0;
      ch_status <= '0;
    end else begin
      res_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (CW'(i) == ch_sel) begin
          if (state == ST_SEL) ch_status[2*i +: 2] <= STAT_UNTESTED;
          if ((state == ST_EVAL) && !abort) ch_status[2*i +: 2] <= eval_status;
        end
      end
      if ((state == ST_EVAL) && !abort) begin
        res_valid <= 1'b1;
        res_ch    <= ch_sel;
        res_r     <= eval_r;
      end
    end
  end

  igniter_avg #(
    .NSAMP (NSAMP)
  ) u_avg (
    .clk     (clk),
    .reset   (reset),
    .clear   (avg_clear),
    .enable  (avg_enable),
    .r_valid (r_valid),
    .r_in    (r_in),
    .full    (avg_full),
    .avg     (avg)
  );

endmodule

// File: tb/tb_igniter_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_igniter_scan_ctrl
// Directed bench for igniter_scan_ctrl with a shortened inter-channel gap.
// -----------------------------------------------------------------------------
module tb_igniter_scan_ctrl;

  localparam int NCH      = 4;
  localparam int CW       = 2;
  localparam int PWM_CYC  = 96;
  localparam int WINDOW_T = 4096;
  localparam int GAP_T    = 1000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic [10:0]      r_open_thr = 11'h200;
  logic [10:0]      r_short_thr = 11'h010;
  logic             r_valid = 1'b0;
  logic [11:0]      r_in = 12'h7FF;
  logic             pwm, busy, done, res_valid;
  logic [CW-1:0]    ch_sel, res_ch;
  logic [10:0]      res_r;
  logic [2*NCH-1:0] ch_status;

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters sampled on the falling edge.
  int            done_cnt = 0;
  int            pwm_cnt  = 0;
  int            res_cnt  = 0;
  logic [CW-1:0] res_ch_log [0:63];
  logic [10:0]   res_r_log  [0:63];
  logic          rv_on = 1'b0;

  igniter_scan_ctrl #(
    .NCH     (NCH),
    .PWM_CYC (PWM_CYC),
    .SETTLE  (256),
    .WINDOW  (WINDOW_T),
    .NSAMP   (16),
    .GAP     (GAP_T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .ch_mask     (ch_mask),
    .r_open_thr  (r_open_thr),
    .r_short_thr (r_short_thr),
    .r_valid     (r_valid),
    .r_in        (r_in),
    .pwm         (pwm),
    .ch_sel      (ch_sel),
    .busy        (busy),
    .done        (done),
    .res_valid   (res_valid),
    .res_ch      (res_ch),
    .res_r       (res_r),
    .ch_status   (ch_status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (pwm)  pwm_cnt  <= pwm_cnt + 1;
    if (res_valid && (res_cnt < 64)) begin
      res_ch_log[res_cnt] <= res_ch;
      res_r_log[res_cnt]  <= res_r;
      res_cnt             <= res_cnt + 1;
    end
  end

  // Sample strobe: one pulse every 8 cycles while enabled.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      r_valid = rv_on && ((k % 8) == 0);
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rv_on = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Returns on the falling edge just after the edge that sampled start.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (pwm !== 1'b0)       begin n_fail++; $display("FAIL rst_pwm: got %b want 0", pwm); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_tests++; if (ch_sel !== 2'd0)    begin n_fail++; $display("FAIL rst_ch_sel: got %0d want 0", ch_sel); end
    n_tests++; if (ch_status !== 8'h00) begin n_fail++; $display("FAIL rst_ch_status: got %b want 00000000", ch_status); end
    n_tests++; if (res_r !== 11'h000)  begin n_fail++; $display("FAIL rst_res_r: got %h want 000", res_r); end
  endtask

  // One OK channel at magnitude 50; the mask changes mid-scan and must be ignored.
  task automatic test_single_ok();
    int d0, p0, r0;
    apply_reset();
    ch_mask = 4'b0001; r_in = 12'h7CD; r_open_thr = 11'h200; r_short_thr = 11'h010;
    rv_on = 1'b1;
    d0 = done_cnt; p0 = pwm_cnt; r0 = res_cnt;
    pulse_start();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ok_busy: got %b want 1", busy); end
    @(negedge clk);
    ch_mask = 4'b1111;
    wait_done(3000, "ok_done_wait");
    repeat (4) @(negedge clk);
    n_tests++; if (pwm_cnt - p0 !== PWM_CYC) begin n_fail++; $display("FAIL ok_pwm_cycles: got %0d want %0d", pwm_cnt - p0, PWM_CYC); end
    n_tests++; if (res_cnt - r0 !== 1) begin n_fail++; $display("FAIL ok_res_count: got %0d want 1", res_cnt - r0); end
    n_tests++; if (res_ch_log[r0] !== 2'd0) begin n_fail++; $display("FAIL ok_res_ch: got %0d want 0", res_ch_log[r0]); end
    n_tests++; if (res_r_log[r0] !== 11'h032) begin n_fail++; $display("FAIL ok_res_r: got %h want 032", res_r_log[r0]); end
    n_tests++; if (ch_status !== 8'b00000001) begin n_fail++; $display("FAIL ok_status: got %b want 00000001", ch_status); end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ok_done_count: got %0d want 1", done_cnt - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ok_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_two_short();
    int d0, r0;
    apply_reset();
    ch_mask = 4'b1010; r_in = 12'h7FE;
    rv_on = 1'b1;
    d0 = done_cnt; r0 = res_cnt;
    pulse_start();
    wait_done(6000, "short_done_wait");
    repeat (4) @(negedge clk);
    n_tests++; if (res_cnt - r0 !== 2) begin n_fail++; $display("FAIL short_res_count: got %0d want 2", res_cnt - r0); end
    n_tests++; if (res_ch_log[r0] !== 2'd1) begin n_fail++; $display("FAIL short_first_ch: got %0d want 1", res_ch_log[r0]); end
    n_tests++; if (res_ch_log[r0+1] !== 2'd3) begin n_fail++; $display("FAIL short_second_ch: got %0d want 3", res_ch_log[r0+1]); end
    n_tests++; if (res_r_log[r0] !== 11'h001) begin n_fail++; $display("FAIL short_first_r: got %h want 001", res_r_log[r0]); end
    n_tests++; if (res_r_log[r0+1] !== 11'h001) begin n_fail++; $display("FAIL short_second_r: got %h want 001", res_r_log[r0+1]); end
    n_tests++; if (ch_status !== 8'b11001100) begin n_fail++; $display("FAIL short_status: got %b want 11001100", ch_status); end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL short_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  // No samples: phase hits WINDOW in MEAS after edge WINDOW+1 (counting the
  // start edge as 0), EVAL follows, and the registered result shows on the
  // falling edge WINDOW+4 counted from the SEL cycle as 1.
  task automatic test_timeout();
    int n;
    apply_reset();
    ch_mask = 4'b0100;
    rv_on = 1'b0;
    pulse_start();
    n = 1;
    while (!res_valid && (n < 6000)) begin
      @(negedge clk);
      n++;
    end
    n_tests++; if (n !== WINDOW_T + 4) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", n, WINDOW_T + 4); end
    n_tests++; if (res_ch !== 2'd2) begin n_fail++; $display("FAIL to_res_ch: got %0d want 2", res_ch); end
    n_tests++; if (res_r !== 11'h7FF) begin n_fail++; $display("FAIL to_res_r: got %h want 7ff", res_r); end
    wait_done(3000, "to_done_wait");
    @(negedge clk);
    n_tests++; if (ch_status !== 8'b00100000) begin n_fail++; $display("FAIL to_status: got %b want 00100000", ch_status); end
  endtask

  task automatic test_abort();
    int d0, p0, r0, n;
    apply_reset();
    ch_mask = 4'b0001; r_in = 12'h7CD;
    rv_on = 1'b1;
    d0 = done_cnt; p0 = pwm_cnt; r0 = res_cnt;
    pulse_start();
    n = 0;
    while (!pwm && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    n_tests++; if (pwm !== 1'b1) begin n_fail++; $display("FAIL ab_pulse_seen: got %b want 1", pwm); end
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL ab_pwm_low: got %b want 0", pwm); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle: busy got %b want 0", busy); end
    repeat (400) @(negedge clk);
    n_tests++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL ab_no_done: got %0d want 0", done_cnt - d0); end
    n_tests++; if (res_cnt - r0 !== 0) begin n_fail++; $display("FAIL ab_no_result: got %0d want 0", res_cnt - r0); end
    n_tests++; if (pwm_cnt - p0 !== 20) begin n_fail++; $display("FAIL ab_pwm_cycles: got %0d want 20", pwm_cnt - p0); end
    n_tests++; if (ch_status !== 8'h00) begin n_fail++; $display("FAIL ab_status: got %b want 00000000", ch_status); end
    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_start_tie: busy got %b want 0", busy); end
    repeat (5) @(negedge clk);
    n_tests++; if (pwm_cnt - p0 !== 20) begin n_fail++; $display("FAIL ab_tie_no_pulse: got %0d want 20", pwm_cnt - p0); end
  endtask

  task automatic test_empty_mask();
    int d0, p0;
    apply_reset();
    ch_mask = 4'b0000;
    d0 = done_cnt; p0 = pwm_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", done); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b want 1", busy); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done_end: got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle: busy got %b want 0", busy); end
    repeat (5) @(negedge clk);
    n_tests++; if (pwm_cnt - p0 !== 0) begin n_fail++; $display("FAIL empty_no_pwm: got %0d want 0", pwm_cnt - p0); end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL empty_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  // Channel 1 completes OK, then reset hits while channel 2 is sampling.
  task automatic test_reset_mid_meas();
    int n, p0;
    apply_reset();
    ch_mask = 4'b0110; r_in = 12'h7CD;
    rv_on = 1'b1;
    pulse_start();
    n = 0;
    while (!res_valid && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while ((ch_sel !== 2'd2) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    // SEL plus 299 further cycles: phase 298, inside MEAS with ~5 samples.
    repeat (299) @(negedge clk);
    n_tests++; if (ch_status !== 8'b00000100) begin n_fail++; $display("FAIL mid_pre_status: got %b want 00000100", ch_status); end
    n_tests++; if (res_r !== 11'h032) begin n_fail++; $display("FAIL mid_pre_res_r: got %h want 032", res_r); end
    n_tests++; if (ch_sel !== 2'd2) begin n_fail++; $display("FAIL mid_pre_ch_sel: got %0d want 2", ch_sel); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_tests++; if (pwm !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_pwm: got %b want 0", pwm); end
    n_tests++; if (ch_sel !== 2'd0)    begin n_fail++; $display("FAIL mid_rst_ch_sel: got %0d want 0", ch_sel); end
    n_tests++; if (ch_status !== 8'h00) begin n_fail++; $display("FAIL mid_rst_status: got %b want 00000000", ch_status); end
    n_tests++; if (res_r !== 11'h000)  begin n_fail++; $display("FAIL mid_rst_res_r: got %h want 000", res_r); end
    n_tests++; if (res_ch !== 2'd0)    begin n_fail++; $display("FAIL mid_rst_res_ch: got %0d want 0", res_ch); end
    n_tests++; if ({done, res_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_strobes: got %b want 00", {done, res_valid}); end
    @(negedge clk);
    reset = 1'b1;
    p0 = pwm_cnt;
    repeat (50) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume: busy got %b want 0", busy); end
    n_tests++; if (pwm_cnt - p0 !== 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d want 0", pwm_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_single_ok();
    test_two_short();
    test_timeout();
    test_abort();
    test_empty_mask();
    test_reset_mid_meas();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
